// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
//   Shared definitions for the RV32I/Zicsr instruction encoder:
//     - mnemonic_e : mnemonic codes in decode-table order, MNEM_COUNT
//     - fmt_e      : instruction formats (R, I, S, B, U, J, SYS)
//     - OPC_*      : major opcode constants
//     - mnem_info  : mnemonic -> {fmt, opcode, funct3, funct7}
//     - NOP_WORD   : canonical NOP (ADDI x0,x0,0)
//     - imm_in_range : immediate legality check, only present when the
//                      optional range check (INSTR_ENC_RANGE_CHECK_EN) is built
// -----------------------------------------------------------------------------
package instr_enc_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, FENCE_I, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } mnemonic_e;

    // First code past the end of the table; anything >= this is undefined.
    localparam logic [5:0] MNEM_COUNT = 6'd47;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
    } mnem_info_t;

    function automatic mnem_info_t mk(fmt_e f, logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        mnem_info_t r;
        r.fmt    = f;
        r.opcode = o;
        r.f3     = f3;
        r.f7     = f7;
        return r;
    endfunction

    function automatic mnem_info_t mnem_info(mnemonic_e m);
        mnem_info_t r;
        case (m)
            LUI:     r = mk(FMT_U,   OPC_LUI,      3'd0, 7'h00);
            AUIPC:   r = mk(FMT_U,   OPC_AUIPC,    3'd0, 7'h00);
            JAL:     r = mk(FMT_J,   OPC_JAL,      3'd0, 7'h00);
            JALR:    r = mk(FMT_I,   OPC_JALR,     3'd0, 7'h00);
            BEQ:     r = mk(FMT_B,   OPC_BRANCH,   3'd0, 7'h00);
            BNE:     r = mk(FMT_B,   OPC_BRANCH,   3'd1, 7'h00);
            BLT:     r = mk(FMT_B,   OPC_BRANCH,   3'd4, 7'h00);
            BGE:     r = mk(FMT_B,   OPC_BRANCH,   3'd5, 7'h00);
            BLTU:    r = mk(FMT_B,   OPC_BRANCH,   3'd6, 7'h00);
            BGEU:    r = mk(FMT_B,   OPC_BRANCH,   3'd7, 7'h00);
            LB:      r = mk(FMT_I,   OPC_LOAD,     3'd0, 7'h00);
            LH:      r = mk(FMT_I,   OPC_LOAD,     3'd1, 7'h00);
            LW:      r = mk(FMT_I,   OPC_LOAD,     3'd2, 7'h00);
            LBU:     r = mk(FMT_I,   OPC_LOAD,     3'd4, 7'h00);
            LHU:     r = mk(FMT_I,   OPC_LOAD,     3'd5, 7'h00);
            SB:      r = mk(FMT_S,   OPC_STORE,    3'd0, 7'h00);
            SH:      r = mk(FMT_S,   OPC_STORE,    3'd1, 7'h00);
            SW:      r = mk(FMT_S,   OPC_STORE,    3'd2, 7'h00);
            ADDI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd0, 7'h00);
            SLTI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd2, 7'h00);
            SLTIU:   r = mk(FMT_I,   OPC_OP_IMM,   3'd3, 7'h00);
            XORI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd4, 7'h00);
            ORI:     r = mk(FMT_I,   OPC_OP_IMM,   3'd6, 7'h00);
            ANDI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd7, 7'h00);
            SLLI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd1, 7'h00);
            SRLI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd5, 7'h00);
            SRAI:    r = mk(FMT_I,   OPC_OP_IMM,   3'd5, 7'h20);
            ADD:     r = mk(FMT_R,   OPC_OP,       3'd0, 7'h00);
            SUB:     r = mk(FMT_R,   OPC_OP,       3'd0, 7'h20);
            SLL:     r = mk(FMT_R,   OPC_OP,       3'd1, 7'h00);
            SLT:     r = mk(FMT_R,   OPC_OP,       3'd2, 7'h00);
            SLTU:    r = mk(FMT_R,   OPC_OP,       3'd3, 7'h00);
            XOR:     r = mk(FMT_R,   OPC_OP,       3'd4, 7'h00);
            SRL:     r = mk(FMT_R,   OPC_OP,       3'd5, 7'h00);
            SRA:     r = mk(FMT_R,   OPC_OP,       3'd5, 7'h20);
            OR:      r = mk(FMT_R,   OPC_OP,       3'd6, 7'h00);
            AND:     r = mk(FMT_R,   OPC_OP,       3'd7, 7'h00);
            FENCE:   r = mk(FMT_SYS, OPC_MISC_MEM, 3'd0, 7'h00);
            FENCE_I: r = mk(FMT_SYS, OPC_MISC_MEM, 3'd1, 7'h00);
            ECALL:   r = mk(FMT_SYS, OPC_SYSTEM,   3'd0, 7'h00);
            EBREAK:  r = mk(FMT_SYS, OPC_SYSTEM,   3'd0, 7'h00);
            CSRRW:   r = mk(FMT_SYS, OPC_SYSTEM,   3'd1, 7'h00);
            CSRRS:   r = mk(FMT_SYS, OPC_SYSTEM,   3'd2, 7'h00);
            CSRRC:   r = mk(FMT_SYS, OPC_SYSTEM,   3'd3, 7'h00);
            CSRRWI:  r = mk(FMT_SYS, OPC_SYSTEM,   3'd5, 7'h00);
            CSRRSI:  r = mk(FMT_SYS, OPC_SYSTEM,   3'd6, 7'h00);
            CSRRCI:  r = mk(FMT_SYS, OPC_SYSTEM,   3'd7, 7'h00);
            // Undefined codes: the top replaces the word with NOP_WORD anyway.
            default: r = mk(FMT_I,   OPC_OP_IMM,   3'd0, 7'h00);
        endcase
        return r;
    endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // True when imm fits the field of mnemonic m without truncation.
    function automatic logic imm_in_range(mnemonic_e m, logic [31:0] imm);
        logic signed [31:0] s;
        logic               ok;
        s  = imm;
        ok = 1'b1;
        case (m)
            JALR, LB, LH, LW, LBU, LHU, SB, SH, SW,
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI:
                ok = (s >= -32'sd2048) && (s <= 32'sd2047);
            BEQ, BNE, BLT, BGE, BLTU, BGEU:
                ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !imm[0];
            JAL:
                ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && !imm[0];
            LUI, AUIPC:
                ok = (imm[11:0] == 12'd0);
            SLLI, SRLI, SRAI:
                ok = (imm <= 32'd31);
            CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI:
                ok = (imm <= 32'd4095);
            FENCE:
                ok = (imm[31:8] == 24'd0);
            default:
                ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Purely combinational bit packer: places already-normalised fields into a
//   32-bit RV32 word according to the instruction format.
//   Ports:
//     fmt_i     format selector
//     opcode_i  major opcode     f3_i / f7_i  funct3 / funct7
//     rd_i, rs1_i, rs2_i         register fields
//     imm_i     immediate (byte offset / U value / 12-bit I field)
//     word_o    packed instruction
//   SYS uses the I layout; the caller has already folded CSR addresses,
//   FENCE pred/succ, EBREAK's funct12 and shift funct7 into imm_i[11:0].
// -----------------------------------------------------------------------------
module instr_pack
    import instr_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  f3_i,
    input  logic [6:0]  f7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = NOP_WORD;
        case (fmt_i)
            FMT_R:   word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
            FMT_I,
            FMT_SYS: word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
            FMT_S:   word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
            // Branch/jump offsets are even; bit 0 is never encoded.
            FMT_B:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
            FMT_U:   word_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J:   word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, opcode_i};
            default: word_o = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns {mnemonic, rd, rs1, rs2, imm} requests into RV32I/Zicsr machine words
//   and streams them with consecutive byte addresses towards instruction memory.
//   Two-stage pipeline: S1 holds the request (format lookup, range check,
//   operand normalisation in front of the S2 register), S2 holds the packed word.
//   Ports:
//     clk, rst_n (sync, active low), clr (sync flush, same effect as reset)
//     req_valid/req_ready, req_mnem, req_rd, req_rs1, req_rs2, req_imm
//     out_valid/out_ready, out_word, out_addr
//     err_pulse (one cycle per dropped / NOP-substituted request)
//     err_cnt   (saturating count of err_pulse)
//   Handshakes: a transfer happens on a rising clk edge where valid && ready;
//   valid is held with stable payload until then; ready never depends on valid.
//   Optional feature macro: INSTR_ENC_RANGE_CHECK_EN -- drop requests whose
//   immediate does not fit its field instead of silently truncating it.
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 1024,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_mnem,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [31:0]          req_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    // S1: raw request
    logic                 s1_valid_q, s1_valid_d;
    logic [5:0]           s1_mnem_q,  s1_mnem_d;
    logic [4:0]           s1_rd_q,    s1_rd_d;
    logic [4:0]           s1_rs1_q,   s1_rs1_d;
    logic [4:0]           s1_rs2_q,   s1_rs2_d;
    logic [31:0]          s1_imm_q,   s1_imm_d;
    // S2: packed word and its address index
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_word_q,  s2_word_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic                 err_q,      err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic       flush;
    logic       s2_adv;
    mnem_info_t info;
    logic       bad_mnem;
    logic       range_viol;
    logic       s1_err;
    logic [4:0] n_rd, n_rs1, n_rs2;
    logic [31:0] n_imm;
    logic [31:0] packed_word;

    assign flush     = !rst_n || clr;
    // S2 can take a new word when empty or when its word leaves this cycle;
    // S1 moves exactly when S2 can take.
    assign s2_adv    = !s2_valid_q || out_ready;
    assign req_ready = rst_n && !clr && (!s1_valid_q || s2_adv);

    // S1 combinational: format lookup, operand normalisation, range check.
    always_comb begin
        info     = mnem_info(mnemonic_e'(s1_mnem_q));
        bad_mnem = (s1_mnem_q >= MNEM_COUNT);
        n_rd     = s1_rd_q;
        n_rs1    = s1_rs1_q;
        n_rs2    = s1_rs2_q;
        n_imm    = s1_imm_q;
        case (mnemonic_e'(s1_mnem_q))
            // Shifts: funct7 occupies imm[11:5]; this is where SRAI gets bit 30.
            SLLI, SRLI, SRAI: n_imm = {20'd0, info.f7, s1_imm_q[4:0]};
            FENCE: begin
                n_rd  = 5'd0;
                n_rs1 = 5'd0;
                n_imm = {24'd0, s1_imm_q[7:0]};
            end
            FENCE_I, ECALL: begin
                n_rd  = 5'd0;
                n_rs1 = 5'd0;
                n_rs2 = 5'd0;
                n_imm = 32'd0;
            end
            EBREAK: begin
                n_rd  = 5'd0;
                n_rs1 = 5'd0;
                n_rs2 = 5'd0;
                n_imm = 32'd1;
            end
            default: ;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        range_viol = !bad_mnem && !imm_in_range(mnemonic_e'(s1_mnem_q), s1_imm_q);
`else
        range_viol = 1'b0;
`endif
        s1_err = s1_valid_q && (bad_mnem || range_viol);
    end

    instr_pack u_pack (
        .fmt_i    (info.fmt),
        .opcode_i (info.opcode),
        .f3_i     (info.f3),
        .f7_i     (info.f7),
        .rd_i     (n_rd),
        .rs1_i    (n_rs1),
        .rs2_i    (n_rs2),
        .imm_i    (n_imm),
        .word_o   (packed_word)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mnem_d  = s1_mnem_q;
        s1_rd_d    = s1_rd_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_imm_d   = s1_imm_q;
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        idx_d      = idx_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (req_ready) begin
            s1_valid_d = req_valid;
        end
        if (req_ready && req_valid) begin
            s1_mnem_d = req_mnem;
            s1_rd_d   = req_rd;
            s1_rs1_d  = req_rs1;
            s1_rs2_d  = req_rs2;
            s1_imm_d  = req_imm;
        end

        if (s2_adv) begin
            // A range-violating request vanishes here: no word, no address.
            s2_valid_d = s1_valid_q && !range_viol;
            if (s1_valid_q && !range_viol) begin
                s2_word_d = bad_mnem ? NOP_WORD : packed_word;
            end
            // Registered so it lines up with out_valid of a NOP substitute,
            // or with the slot a dropped request would have occupied.
            err_d = s1_err;
            if (s1_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        if (s2_valid_q && out_ready) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid_q <= 1'b0;
            s1_mnem_q  <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mnem_q  <= s1_mnem_d;
            s1_rd_q    <= s1_rd_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_imm_q   <= s1_imm_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_word  = s2_word_q;
    assign out_addr  = BASE_ADDR + (ADDR_W'(idx_q) << 2);
    assign err_pulse = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import instr_enc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr;
    logic        req_valid, req_ready;
    logic [5:0]  req_mnem;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_word, out_addr;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .DEPTH     (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mnem  (req_mnem),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected {addr, word}, in emission order.
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected address sequence: BASE 0, DEPTH 4 -> 0,4,8,12,0,...
    task automatic push(input logic [31:0] word);
        exp_q.push_back({exp_addr, word});
        exp_addr = (exp_addr + 32'd4) % 32'd16;
    endtask

    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: observed %0h expected none", {out_addr, out_word});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_word", {out_addr, out_word}, e);
            end
        end
    end

    // ---------------- driver tasks (all start/end at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_mnem  = m;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_valid = 1'b1;
    endtask

    task automatic send(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int waited = 0;
        set_req(m, rd, rs1, rs2, imm);
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: observed req_ready 0 expected 1");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        exp_addr = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        req_valid = 1'b0;
        req_mnem  = '0;
        req_rd    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_imm   = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word",  64'(out_word),  64'd0);
        check("rst_out_addr",  64'(out_addr),  64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_err_cnt",   64'(err_cnt),   64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1. ADDI x1,x0,5, latency
        push(32'h0050_0093);
        set_req(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("t1_lat_s1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_lat_s2",  64'(out_valid), 64'd1);
        check("t1_word",    64'(out_word),  64'h0050_0093);
        check("t1_addr",    64'(out_addr),  64'd0);
        tick();

        // 2. Assorted formats, back to back
        push(32'hFE20_8CE3); send(BEQ,    5'd0, 5'd1, 5'd2, -32'sd8);
        push(32'h0010_00EF); send(JAL,    5'd1, 5'd0, 5'd0, 32'd2048);
        push(32'h4041_D193); send(SRAI,   5'd3, 5'd3, 5'd0, 32'd4);
        push(32'h1234_52B7); send(LUI,    5'd5, 5'd0, 5'd0, 32'h1234_5000);
        push(32'h0020_A423); send(SW,     5'd0, 5'd1, 5'd2, 32'd8);
        push(32'h4020_81B3); send(SUB,    5'd3, 5'd1, 5'd2, 32'd0);
        push(32'h3001_10F3); send(CSRRW,  5'd1, 5'd2, 5'd0, 32'h300);
        push(32'h0FF0_000F); send(FENCE,  5'd7, 5'd9, 5'd3, 32'hFF);
        push(32'h0010_0073); send(EBREAK, 5'd7, 5'd9, 5'd3, 32'hDEAD);
        push(32'h0000_0073); send(ECALL,  5'd1, 5'd2, 5'd3, 32'h55);
        wait_drain();

        // 3. Stall: two accepted, then back-pressure, then in-order release
        do_clr();
        out_ready = 1'b0;
        push(32'h0010_0093);
        push(32'h0020_0093);
        push(32'h0030_0093);
        set_req(ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        @(negedge clk);
        check("t3_ready_a", 64'(req_ready), 64'd1);
        tick();
        set_req(ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        check("t3_ready_b", 64'(req_ready), 64'd1);
        tick();
        set_req(ADDI, 5'd1, 5'd0, 5'd0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", 64'(req_ready), 64'd0);
            check("t3_stall_valid", 64'(out_valid), 64'd1);
            check("t3_stall_word",  64'(out_word),  64'h0010_0093);
            check("t3_stall_addr",  64'(out_addr),  64'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        wait_drain();

        // 4. Out-of-range immediate
        do_clr();
`ifdef INSTR_ENC_RANGE_CHECK_EN
        send(ADDI, 5'd0, 5'd0, 5'd0, 32'd4096);
        @(negedge clk);
        check("t4_err_early", 64'(err_pulse), 64'd0);
        tick();
        @(negedge clk);
        check("t4_err_pulse", 64'(err_pulse), 64'd1);
        check("t4_no_valid",  64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t4_err_end",   64'(err_pulse), 64'd0);
        check("t4_err_cnt",   64'(err_cnt),   64'd1);
        check("t4_no_valid2", 64'(out_valid), 64'd0);
        tick();
`else
        push(NOP_WORD);
        send(ADDI, 5'd0, 5'd0, 5'd0, 32'd4096);
        @(negedge clk);
        check("t4_err_early", 64'(err_pulse), 64'd0);
        tick();
        @(negedge clk);
        check("t4_err_pulse", 64'(err_pulse), 64'd0);
        check("t4_valid",     64'(out_valid), 64'd1);
        check("t4_word",      64'(out_word),  64'h0000_0013);
        tick();
        @(negedge clk);
        check("t4_err_cnt",   64'(err_cnt),   64'd0);
        tick();
`endif
        push(32'h0050_0093);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        wait_drain();

        // 5. Address wrap with DEPTH=4, then undefined mnemonic
        do_clr();
        for (int k = 1; k <= 5; k++) begin
            push(32'h0000_0093 | (32'(k) << 20));
            send(ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
        end
        wait_drain();
        check("t5_addr_after_wrap", 64'(out_addr), 64'd4);
        push(NOP_WORD);
        send(6'd63, 5'd4, 5'd5, 5'd6, 32'h1234);
        @(negedge clk);
        check("t5_err_early",  64'(err_pulse), 64'd0);
        check("t5_valid_early", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t5_err_pulse",  64'(err_pulse), 64'd1);
        check("t5_valid",      64'(out_valid), 64'd1);
        check("t5_nop_word",   64'(out_word),  64'h0000_0013);
        check("t5_nop_addr",   64'(out_addr),  64'd4);
        tick();
        @(negedge clk);
        check("t5_err_end",    64'(err_pulse), 64'd0);
        check("t5_err_cnt",    64'(err_cnt),   64'd1);
        tick();
        wait_drain();

        // 6a. rst_n while full and stalled
        out_ready = 1'b0;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd7);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd8);
        @(negedge clk);
        check("t6a_full", 64'(out_valid), 64'd1);
        check("t6a_pre_addr", 64'(out_addr), 64'd8);
        tick();
        set_req(ADDI, 5'd1, 5'd0, 5'd0, 32'd9);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6a_ready_in_rst", 64'(req_ready), 64'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        exp_addr = 32'd0;
        @(negedge clk);
        check("t6a_valid", 64'(out_valid), 64'd0);
        check("t6a_addr",  64'(out_addr),  64'd0);
        check("t6a_cnt",   64'(err_cnt),   64'd0);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("t6a_no_stale", 64'(out_valid), 64'd0);
        tick();

        // 6b. clr while full and stalled
        push(NOP_WORD);
        send(6'd50, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_drain();
        check("t6b_pre_cnt", 64'(err_cnt), 64'd1);
        out_ready = 1'b0;
        send(ADDI, 5'd2, 5'd0, 5'd0, 32'd1);
        send(ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
        set_req(ADDI, 5'd2, 5'd0, 5'd0, 32'd3);
        clr = 1'b1;
        tick();
        clr       = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        exp_addr = 32'd0;
        @(negedge clk);
        check("t6b_valid", 64'(out_valid), 64'd0);
        check("t6b_addr",  64'(out_addr),  64'd0);
        check("t6b_cnt",   64'(err_cnt),   64'd0);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("t6b_no_stale", 64'(out_valid), 64'd0);
        tick();

        // 7. err_cnt saturates at all-ones
        do_clr();
        for (int i = 0; i < 256; i++) begin
            push(NOP_WORD);
            send(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
        end
        wait_drain();
        @(negedge clk);
        check("t7_err_sat", 64'(err_cnt), 64'd255);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
